fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 114 +++++++++++
 tb/tb_fetch_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a program ROM from pc, presents each
// word to the processor with a valid/ready handshake, redirects or halts.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               start request, sampled only while idle
//   rom_en/rom_addr   ROM read strobe and address (address is pc)
//   rom_data          ROM read data, one cycle after rom_en
//   instr/instr_valid instruction to the processor and its valid flag
//   instr_ready       processor accepts instr this cycle
//   branch_req/target redirect taken only in a transfer cycle
//   pc                current program counter
//   halt              halted after a HALT_OP instruction was accepted
//   instr_count       accepted instructions, saturating
module fetch_controller #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halt,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_HALTED
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [DATA_W-1:0]   instr_n;
  logic [15:0]         cnt_n;
  logic                xfer;
  logic                is_halt;

  assign xfer    = (state == S_PRESENT) && instr_ready;
  assign is_halt = (instr[DATA_W-1 -: 4] == HALT_OP);

  // Strobes are pure functions of the state, so they are low in
  // every cycle that follows a reset edge.
  assign rom_en      = (state == S_FETCH);
  assign rom_addr    = pc;
  assign instr_valid = (state == S_PRESENT);
  assign halt        = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    cnt_n   = instr_count;
    unique case (state)
      S_IDLE: begin
        if (run) state_n = S_FETCH;
      end
      S_FETCH: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        instr_n = rom_data;
        state_n = S_PRESENT;
      end
      S_PRESENT: begin
        if (xfer) begin
          if (instr_count != 16'hFFFF)
            cnt_n = instr_count + 16'd1;
          if (is_halt) begin
            state_n = S_HALTED;
          end else begin
            // pc+1 wraps naturally at ADDR_W bits
            pc_n    = branch_req ? branch_target
                                 : pc + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_n = S_HALTED;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run against a cycle-count reference model of the fetch loop.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        run;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_req;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic        halt;
  logic [15:0] instr_count;

  int tests;
  int fails;

  logic [15:0] rom [256];

  fetch_controller #(
    .ADDR_W (8),
    .DATA_W (16),
    .HALT_OP(4'hF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .pc           (pc),
    .halt         (halt),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM; outside a read the data bus carries noise so a
  // capture in the wrong cycle is visible.
  always @(posedge clk)
    rom_data <= rom_en ? rom[rom_addr] : 16'($urandom);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; run = 0; instr_ready = 0;
    branch_req = 0; branch_target = 0;
    tick();
    rst = 0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1; run = 1; instr_ready = 1;
    branch_req = 1; branch_target = 8'h55;
    tick();
    tests++;
    if ({pc, instr, instr_valid, rom_en, rom_addr, halt, instr_count}
        !== '0) begin
      fails++;
      $display("FAIL reset_state: pc=%h instr=%h v=%b en=%b addr=%h h=%b cnt=%0d, required all zero",
               pc, instr, instr_valid, rom_en, rom_addr, halt, instr_count);
    end
    tick();
    tests++;
    if (rom_en !== 0 || instr_valid !== 0 || pc !== 0) begin
      fails++;
      $display("FAIL reset_override: en=%b v=%b pc=%h, required 0 0 00",
               rom_en, instr_valid, pc);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    logic [15:0] got [$];
    logic [15:0] exp [3];
    exp[0] = 16'h1001; exp[1] = 16'h1002; exp[2] = 16'hF000;
    rom[0] = exp[0]; rom[1] = exp[1]; rom[2] = exp[2];
    do_reset();
    run = 1; instr_ready = 1;
    tick();
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid === 1'b1) got.push_back(instr);
      if (halt === 1'b1) break;
      tick();
    end
    tests++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL seq_count: got %0d instrs, required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got[i] !== exp[i]) begin
          fails++;
          $display("FAIL seq_instr%0d: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
    tests++;
    if (halt !== 1 || pc !== 8'd2 || instr_count !== 16'd3) begin
      fails++;
      $display("FAIL seq_end: halt=%b pc=%h cnt=%0d, required 1 02 3",
               halt, pc, instr_count);
    end
    run = 1;
    repeat (4) tick();
    run = 0;
    tests++;
    if (halt !== 1 || rom_en !== 0 || instr_valid !== 0) begin
      fails++;
      $display("FAIL halted_sticky: halt=%b en=%b v=%b, required 1 0 0",
               halt, rom_en, instr_valid);
    end
  endtask

  task automatic test_branch();
    bit ok;
    rom[0] = 16'h2000;
    rom[8'h40] = 16'h2040;
    do_reset();
    run = 1;
    tick();
    run = 0;
    instr_ready = 1; branch_req = 1; branch_target = 8'h77;
    wait_valid(10, ok);
    tests++;
    if (!ok || pc !== 8'h00 || instr !== 16'h2000) begin
      fails++;
      $display("FAIL branch_early: ok=%b pc=%h instr=%h, required 1 00 2000",
               ok, pc, instr);
    end
    branch_target = 8'h40;
    tick();
    branch_req = 0; instr_ready = 0;
    tests++;
    if (rom_en !== 1 || rom_addr !== 8'h40 || instr_count !== 16'd1) begin
      fails++;
      $display("FAIL branch_taken: en=%b addr=%h cnt=%0d, required 1 40 1",
               rom_en, rom_addr, instr_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rom[0] = 16'h1234;
    rom[1] = 16'h1235;
    do_reset();
    run = 1;
    tick();
    run = 0;
    wait_valid(10, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_wait: instr_valid never rose, required within 10 cycles");
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (instr_valid !== 1 || instr !== 16'h1234 || rom_en !== 0 ||
          instr_count !== 0 || pc !== 0) begin
        fails++;
        $display("FAIL bp_hold%0d: v=%b instr=%h en=%b cnt=%0d pc=%h, required 1 1234 0 0 00",
                 k, instr_valid, instr, rom_en, instr_count, pc);
      end
      tick();
    end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    tests++;
    if (instr_valid !== 0 || instr_count !== 16'd1) begin
      fails++;
      $display("FAIL bp_release: v=%b cnt=%0d, required 0 1", instr_valid, instr_count);
    end
    repeat (6) tick();
    tests++;
    if (instr_count !== 16'd1 || instr_valid !== 1 || instr !== 16'h1235) begin
      fails++;
      $display("FAIL bp_single: cnt=%0d v=%b instr=%h, required 1 1 1235",
               instr_count, instr_valid, instr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    rom[0] = 16'h3000;
    rom[8'hFF] = 16'h3001;
    do_reset();
    run = 1;
    tick();
    run = 0;
    wait_valid(10, ok);
    instr_ready = 1; branch_req = 1; branch_target = 8'hFF;
    tick();
    instr_ready = 0; branch_req = 0;
    wait_valid(10, ok);
    tests++;
    if (!ok || pc !== 8'hFF || instr !== 16'h3001) begin
      fails++;
      $display("FAIL wrap_at_ff: ok=%b pc=%h instr=%h, required 1 ff 3001",
               ok, pc, instr);
    end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    tests++;
    if (rom_en !== 1 || rom_addr !== 8'h00 || pc !== 8'h00) begin
      fails++;
      $display("FAIL wrap_next: en=%b addr=%h pc=%h, required 1 00 00",
               rom_en, rom_addr, pc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    rom[0] = 16'h4000;
    rom[1] = 16'h4001;
    do_reset();
    run = 1;
    tick();
    run = 0;
    tick();
    rst = 1; instr_ready = 1;
    tick();
    rst = 0;
    tests++;
    if (pc !== 0 || instr_valid !== 0 || rom_en !== 0) begin
      fails++;
      $display("FAIL rst_wait: pc=%h v=%b en=%b, required 00 0 0",
               pc, instr_valid, rom_en);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid === 1'b1 || rom_en === 1'b1) seen = 1;
      tick();
    end
    tests++;
    if (seen || instr_count !== 0) begin
      fails++;
      $display("FAIL rst_wait_quiet: activity=%b cnt=%0d, required 0 0",
               seen, instr_count);
    end
    instr_ready = 0;
    run = 1;
    tick();
    run = 0;
    wait_valid(10, ok);
    instr_ready = 1; rst = 1;
    tick();
    rst = 0; instr_ready = 0;
    tests++;
    if (!ok || instr_valid !== 0 || instr_count !== 0 || pc !== 0) begin
      fails++;
      $display("FAIL rst_present: ok=%b v=%b cnt=%0d pc=%h, required 1 0 0 00",
               ok, instr_valid, instr_count, pc);
    end
  endtask

  task automatic test_timing();
    bit exp_en;
    bit exp_v;
    for (int i = 0; i < 256; i++) rom[i] = 16'(16'h5000 + i);
    do_reset();
    instr_ready = 1;
    for (int t = 0; t <= 20; t++) begin
      exp_en = (t >= 11) && ((t - 11) % 3 == 0);
      exp_v  = (t >= 13) && ((t - 13) % 3 == 0);
      tests++;
      if (rom_en !== exp_en || instr_valid !== exp_v) begin
        fails++;
        $display("FAIL timing_t%0d: en=%b v=%b, required %b %b",
                 t, rom_en, instr_valid, exp_en, exp_v);
      end
      run = (t == 10);
      tick();
    end
    run = 0;
    instr_ready = 0;
  endtask

  // Reference: the program advances one accepted instruction at a time;
  // each instruction becomes valid 3 cycles after the run or transfer
  // that requested it and its read strobe is 2 cycles before that.
  task automatic test_random();
    bit          mact;
    bit          mhalt;
    logic [7:0]  mpc;
    logic [15:0] mcnt;
    int          mvalid_at;
    bit          r, rn, rdy, br;
    logic [7:0]  tgt;
    bit          exp_en, exp_v;
    logic [3:0]  op;
    for (int ep = 0; ep < 4; ep++) begin
      for (int i = 0; i < 256; i++) begin
        op = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 29) == 0) op = 4'hF;
        rom[i] = {op, 12'($urandom)};
      end
      do_reset();
      mact = 0; mhalt = 0; mpc = 0; mcnt = 0; mvalid_at = 0;
      for (int c = 0; c < 400; c++) begin
        exp_en = mact && !mhalt && (c == mvalid_at - 2);
        exp_v  = mact && !mhalt && (c >= mvalid_at);
        tests++;
        if (pc !== mpc || rom_addr !== mpc || halt !== mhalt ||
            instr_count !== mcnt) begin
          fails++;
          $display("FAIL rnd_state e%0d c%0d: pc=%h addr=%h halt=%b cnt=%0d, required %h %h %b %0d",
                   ep, c, pc, rom_addr, halt, instr_count, mpc, mpc, mhalt, mcnt);
        end
        tests++;
        if (rom_en !== exp_en || instr_valid !== exp_v) begin
          fails++;
          $display("FAIL rnd_strobe e%0d c%0d: en=%b v=%b, required %b %b",
                   ep, c, rom_en, instr_valid, exp_en, exp_v);
        end
        if (exp_v) begin
          tests++;
          if (instr !== rom[mpc]) begin
            fails++;
            $display("FAIL rnd_instr e%0d c%0d: instr=%h, required %h",
                     ep, c, instr, rom[mpc]);
          end
        end
        r   = ($urandom_range(0, 99) == 0);
        rn  = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        br  = ($urandom_range(0, 3) == 0);
        tgt = 8'($urandom);
        if (r) begin
          mact = 0; mhalt = 0; mpc = 0; mcnt = 0;
        end else if (!mact) begin
          if (rn) begin
            mact = 1;
            mvalid_at = c + 3;
          end
        end else if (!mhalt && c >= mvalid_at && rdy) begin
          if (mcnt != 16'hFFFF) mcnt++;
          if (rom[mpc][15:12] == 4'hF) begin
            mhalt = 1;
          end else begin
            mpc = br ? tgt : mpc + 8'd1;
            mvalid_at = c + 3;
          end
        end
        rst = r; run = rn; instr_ready = rdy;
        branch_req = br; branch_target = tgt;
        tick();
      end
      rst = 0; run = 0; instr_ready = 0; branch_req = 0;
    end
  endtask

  initial begin
    clk = 0; rst = 1; run = 0; instr_ready = 0;
    branch_req = 0; branch_target = 0;
    tests = 0; fails = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    repeat (2) tick();
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_timing();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
